mesh_dma_scheduler: RTL

//  Arbitrates the NN accelerator's DMA read and write requests onto the single manycore endpoint outgoing-packet port.

---
 rtl/mesh_dma_pkg.sv | 20 ++
 rtl/mesh_dma_scheduler_if.sv | 43 ++++
 rtl/mesh_dma_req_buf.sv | 37 +++
 rtl/mesh_dma_scheduler.sv | 115 +++++++++++
 4 files changed

// File: rtl/mesh_dma_pkg.sv
// Shared types for the mesh DMA scheduler: FSM states, the buffered request word,
// and the outstanding-counter width helper.
package mesh_dma_pkg;

  localparam int DMA_ADDR_W = 3;
  localparam int DMA_DATA_W = 32;

  typedef enum logic [1:0] {eRun, eDrain, eDone} dma_state_e;

  typedef struct packed {
    logic                  we;
    logic [DMA_ADDR_W-1:0] addr;
    logic [DMA_DATA_W-1:0] data;
  } dma_req_s;

  function automatic int ctr_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/mesh_dma_scheduler_if.sv
// Accelerator-side and endpoint-side signals of the mesh DMA scheduler.
// slave = scheduler view, master = the surrounding logic (accelerator + endpoint).
interface mesh_dma_scheduler_if #(
  parameter int addr_width_p = 3,
  parameter int data_width_p = 32,
  parameter int ctr_width_p  = 5
);
  logic                    wr_v_i;
  logic [addr_width_p-1:0] wr_addr_i;
  logic [data_width_p-1:0] wr_data_i;
  logic                    wr_ready_o;
  logic                    rd_v_i;
  logic [addr_width_p-1:0] rd_addr_i;
  logic                    rd_ready_o;
  logic [data_width_p-1:0] rd_data_o;
  logic                    rd_data_v_o;
  logic                    out_v_o;
  logic                    out_we_o;
  logic [addr_width_p-1:0] out_addr_o;
  logic [data_width_p-1:0] out_data_o;
  logic                    out_ready_i;
  logic                    resp_v_i;
  logic                    resp_load_i;
  logic [data_width_p-1:0] resp_data_i;
  logic                    fence_i;
  logic                    fence_done_o;
  logic [ctr_width_p-1:0]  outstanding_o;
  logic                    err_o;

  modport slave (
    input  wr_v_i, wr_addr_i, wr_data_i, rd_v_i, rd_addr_i, out_ready_i,
           resp_v_i, resp_load_i, resp_data_i, fence_i,
    output wr_ready_o, rd_ready_o, rd_data_o, rd_data_v_o, out_v_o, out_we_o,
           out_addr_o, out_data_o, fence_done_o, outstanding_o, err_o
  );

  modport master (
    output wr_v_i, wr_addr_i, wr_data_i, rd_v_i, rd_addr_i, out_ready_i,
           resp_v_i, resp_load_i, resp_data_i, fence_i,
    input  wr_ready_o, rd_ready_o, rd_data_o, rd_data_v_o, out_v_o, out_we_o,
           out_addr_o, out_data_o, fence_done_o, outstanding_o, err_o
  );
endinterface

// File: rtl/mesh_dma_req_buf.sv
// One-entry valid/ready holding register for a DMA request. Refills in the same
// cycle it launches, so a steady requester sustains one op per cycle.
module mesh_dma_req_buf
  import mesh_dma_pkg::*;
(
  input  logic     clk_i,
  input  logic     reset_n_i,
  input  logic     i_live,
  input  logic     i_v,
  input  dma_req_s i_req,
  input  logic     i_launch,
  output logic     o_ready,
  output logic     o_full,
  output dma_req_s o_req
);
  logic     r_full;
  dma_req_s r_req;
  logic     w_accept;

  // i_live keeps ready low through reset so every output reads 0 there.
  assign o_ready  = i_live & (~r_full | i_launch);
  assign w_accept = i_v & o_ready;
  assign o_full   = r_full;
  assign o_req    = r_req;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_full <= 1'b0;
      r_req  <= '0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_req  <= i_req;
    end else if (i_launch) begin
      r_full <= 1'b0;
    end
  end
endmodule

// File: rtl/mesh_dma_scheduler.sv
// Arbitrates accelerator DMA stores/loads onto the manycore endpoint packet port,
// bounds outstanding ops to max_out_p, returns load data and runs the fence handshake.
module mesh_dma_scheduler
  import mesh_dma_pkg::*;
#(
  parameter int addr_width_p = DMA_ADDR_W,
  parameter int data_width_p = DMA_DATA_W,
  parameter int max_out_p    = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  mesh_dma_scheduler_if.slave  bus
);
  localparam int                      ctr_width_lp = ctr_width(max_out_p);
  localparam logic [ctr_width_lp-1:0] max_out_lp   = ctr_width_lp'(max_out_p);

  logic                    r_live;
  dma_state_e              r_state, w_state_nxt;
  logic                    r_done_pulsed;
  logic [ctr_width_lp-1:0] r_cnt, w_cnt_nxt;
  logic                    r_rr_rd, r_hold_v, r_hold_rd;
  logic                    r_err, r_rd_data_v;
  logic [data_width_p-1:0] r_rd_data;

  dma_req_s                w_wr_in, w_rd_in, w_wr_q, w_rd_q, w_sel;
  logic                    w_wr_full, w_rd_full, w_sel_rd;
  logic                    w_elig, w_out_v, w_launch, w_resp_ok, w_fence_done;
  logic [addr_width_p-1:0] w_out_addr;

  assign w_wr_in = '{we: 1'b1, addr: bus.wr_addr_i, data: bus.wr_data_i};
  assign w_rd_in = '{we: 1'b0, addr: bus.rd_addr_i, data: '0};

  mesh_dma_req_buf u_wr_buf (
    .clk_i, .reset_n_i, .i_live(r_live), .i_v(bus.wr_v_i), .i_req(w_wr_in),
    .i_launch(w_launch & ~w_sel_rd), .o_ready(bus.wr_ready_o), .o_full(w_wr_full), .o_req(w_wr_q)
  );

  mesh_dma_req_buf u_rd_buf (
    .clk_i, .reset_n_i, .i_live(r_live), .i_v(bus.rd_v_i), .i_req(w_rd_in),
    .i_launch(w_launch & w_sel_rd), .o_ready(bus.rd_ready_o), .o_full(w_rd_full), .o_req(w_rd_q)
  );

  // A stalled grant is pinned until it launches; otherwise round-robin among full buffers.
  always_comb begin
    w_sel_rd = 1'b0;
    if (r_hold_v)                   w_sel_rd = r_hold_rd;
    else if (w_wr_full && w_rd_full) w_sel_rd = r_rr_rd;
    else                             w_sel_rd = w_rd_full;
  end

  assign w_elig     = (r_state == eRun) && (r_cnt < max_out_lp);
  assign w_sel      = w_sel_rd ? w_rd_q : w_wr_q;
  assign w_out_v    = w_elig && (w_sel_rd ? w_rd_full : w_wr_full);
  assign w_launch   = w_out_v & bus.out_ready_i;
  assign w_out_addr = w_sel.addr;

  // A response with nothing outstanding is an error and must not wrap the counter.
  assign w_resp_ok = bus.resp_v_i && (r_cnt != '0);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_launch && !w_resp_ok)      w_cnt_nxt = r_cnt + ctr_width_lp'(1);
    else if (!w_launch && w_resp_ok) w_cnt_nxt = r_cnt - ctr_width_lp'(1);
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_fence_done = 1'b0;
    unique case (r_state)
      eRun:   if (bus.fence_i) w_state_nxt = eDrain;
      eDrain: if (w_cnt_nxt == '0) w_state_nxt = eDone;
      eDone: begin
        w_fence_done = ~r_done_pulsed;
        if (!bus.fence_i) w_state_nxt = eRun;
      end
      default: w_state_nxt = eRun;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_live        <= 1'b0;
      r_state       <= eRun;
      r_done_pulsed <= 1'b0;
      r_cnt         <= '0;
      r_rr_rd       <= 1'b1;
      r_hold_v      <= 1'b0;
      r_hold_rd     <= 1'b0;
      r_err         <= 1'b0;
      r_rd_data_v   <= 1'b0;
      r_rd_data     <= '0;
    end else begin
      r_live        <= 1'b1;
      r_state       <= w_state_nxt;
      r_done_pulsed <= (r_state == eDone) && (w_state_nxt == eDone);
      r_cnt         <= w_cnt_nxt;
      if (w_launch) r_rr_rd <= ~w_sel_rd;
      r_hold_v      <= w_out_v & ~bus.out_ready_i;
      r_hold_rd     <= w_sel_rd;
      r_err         <= r_err | (bus.resp_v_i && (r_cnt == '0));
      r_rd_data_v   <= bus.resp_v_i & bus.resp_load_i;
      r_rd_data     <= bus.resp_data_i;
    end
  end

  assign bus.out_v_o       = w_out_v;
  assign bus.out_we_o      = w_sel.we;
  assign bus.out_addr_o    = w_out_addr;
  assign bus.out_data_o    = w_sel.data;
  assign bus.rd_data_o     = r_rd_data;
  assign bus.rd_data_v_o   = r_rd_data_v;
  assign bus.fence_done_o  = w_fence_done;
  assign bus.outstanding_o = r_cnt;
  assign bus.err_o         = r_err;
endmodule
